// File: rtl/ratio_reducer_n.sv
// N-operand digit GCD reducer: operands entered by button, sequential GCD search,
// reduced operands shown on one active-low 7-segment digit, then a GCD countdown.

module ratio_lane (
  input  logic [3:0] op,
  input  logic [3:0] div,
  output logic       ok,
  output logic [3:0] quo
);
  always_comb begin
    ok  = 1'b0;
    quo = '0;
    if (div != 4'd0) begin
      ok  = (op % div) == 4'd0;
      quo = op / div;
    end
  end
endmodule

module ratio_reducer_n #(
  parameter  int N_CH  = 4,
  parameter  int MOD   = 10,
  parameter  int NUM   = 50_000_000,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] select,
  input  logic             add,
  input  logic             next,
  input  logic [3:0]       data_in,
  output logic [6:0]       data_out,
  output logic [1:0]       state_out,
  output logic             busy
);
  localparam int             TW    = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [TW-1:0]  TLAST = TW'(NUM - 1);
  localparam logic [3:0]     JTOP  = 4'(MOD - 1);
  localparam logic [4:0]     MOD5  = 5'(MOD);

  typedef enum logic [1:0] {SETUP = 2'd0, GCD = 2'd1, RESULT = 2'd2, COUNT = 2'd3} state_t;

  state_t                 state;
  logic [N_CH-1:0][3:0]   op, res, quo;
  logic [N_CH-1:0]        ok;
  logic [3:0]             j, gcd, count, div;
  logic [TW-1:0]          timer;
  logic                   add_q, next_q, add_p, next_p, all_ok;
  logic [SEL_W-1:0]       s;
  logic [4:0]             sum, wrapped;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000; 4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100; 4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001; 4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010; 4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000; 4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000; 4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110; 4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110; default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign add_p     = add & ~add_q;
  assign next_p    = next & ~next_q;
  assign s         = (int'(select) < N_CH) ? select : '0;
  assign sum       = {1'b0, op[s]} + {1'b0, data_in};
  assign wrapped   = sum % MOD5;
  assign all_ok    = &ok;
  assign state_out = state;

  // One divisibility checker per operand, shared by the GCD search (j) and the
  // countdown early-exit test (count).
  assign div = (state == COUNT) ? count : j;

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    ratio_lane u_lane (.op(op[i]), .div(div), .ok(ok[i]), .quo(quo[i]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SETUP;
      op       <= '0;
      res      <= '0;
      j        <= '0;
      gcd      <= '0;
      count    <= '0;
      timer    <= '0;
      busy     <= 1'b0;
      add_q    <= 1'b0;
      next_q   <= 1'b0;
      data_out <= 7'b1000000;
    end else begin
      add_q  <= add;
      next_q <= next;
      case (state)
        SETUP: begin
          data_out <= hex7(op[s]);
          if (add_p) op[s] <= wrapped[3:0];
          if (next_p) begin
            state <= GCD;
            j     <= JTOP;
            busy  <= 1'b1;
          end
        end
        GCD: begin
          if (all_ok) begin
            gcd   <= j;
            res   <= quo;
            busy  <= 1'b0;
            state <= RESULT;
          end else begin
            j <= j - 4'd1;
          end
        end
        RESULT: begin
          data_out <= hex7(res[s]);
          if (next_p) begin
            count <= gcd;
            timer <= '0;
            state <= COUNT;
          end
        end
        default: begin
          data_out <= hex7(count);
          // count is never 0 while here, so all_ok alone qualifies the early exit
          if (next_p && all_ok) begin
            state <= SETUP;
          end else if (timer == TLAST) begin
            timer <= '0;
            count <= count - 4'd1;
            if (count == 4'd1) state <= SETUP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
      endcase
    end
  end
endmodule
